// File: rtl/ysyx_24100029_rr_arbiter4_if.sv
// Handshake bundle between the 4-way round-robin arbiter
// and its requesters / downstream one-hot mux.
interface ysyx_24100029_rr_arbiter4_if;
  logic [3:0] req_i;
  logic [3:0] req_ready_o;
  logic [3:0] gnt_o;
  logic [1:0] gnt_idx_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic       done_i;
  logic       busy_o;
  logic       timeout_o;

  modport master (
    input  req_i,
    input  out_ready_i,
    input  done_i,
    output req_ready_o,
    output gnt_o,
    output gnt_idx_o,
    output out_valid_o,
    output busy_o,
    output timeout_o
  );

  modport slave (
    output req_i,
    output out_ready_i,
    output done_i,
    input  req_ready_o,
    input  gnt_o,
    input  gnt_idx_o,
    input  out_valid_o,
    input  busy_o,
    input  timeout_o
  );
endinterface

// File: rtl/ysyx_24100029_rr_arbiter4.sv
// 4-requester round-robin arbiter with optional response
// lock and grant watchdog; gnt_o is the one-hot mux select.
module ysyx_24100029_rr_arbiter4 #(
  parameter bit          LOCK_RESP   = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic clk,
  input  logic rst_n,
  ysyx_24100029_rr_arbiter4_if.master bus
);

  localparam bit WD_EN = (TIMEOUT_CYC != 0);
  localparam int CW =
    WD_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] CMAX =
    CW'(WD_EN ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            to_q, to_d;
  logic [1:0]      pick;
  logic            found;
  logic            wd_hit;
  logic [3:0]      gnt;
  logic            in_req;

  assign in_req = (state_q == S_REQ);
  assign wd_hit = WD_EN && (cnt_q == CMAX);

  // first requester at or after ptr, wrapping mod 4
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && bus.req_i[ptr_q + 2'(i)]) begin
        pick  = ptr_q + 2'(i);
        found = 1'b1;
      end
    end
  end

  // next state; a normal exit always beats the watchdog
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_REQ;
          idx_d   = pick;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (!bus.req_i[idx_q]) begin
          state_d = S_IDLE;
        end else if (bus.out_ready_i) begin
          if (LOCK_RESP) begin
            state_d = S_RESP;
          end else begin
            state_d = S_IDLE;
            ptr_d   = idx_q + 2'd1;
          end
        end else if (wd_hit) begin
          state_d = S_IDLE;
          ptr_d   = idx_q + 2'd1;
          to_d    = 1'b1;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.done_i) begin
          state_d = S_IDLE;
          ptr_d   = idx_q + 2'd1;
        end else if (wd_hit) begin
          state_d = S_IDLE;
          ptr_d   = idx_q + 2'd1;
          to_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers, reset drops any grant at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign gnt = (state_q != S_IDLE)
             ? (4'b0001 << idx_q) : 4'b0000;

  assign bus.gnt_o       = gnt;
  assign bus.gnt_idx_o   = idx_q;
  assign bus.out_valid_o = in_req & bus.req_i[idx_q];
  assign bus.req_ready_o = in_req
                         ? (gnt & {4{bus.out_ready_i}})
                         : 4'b0000;
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.timeout_o   = to_q;

endmodule
